mptw_flush_controller: RTL and testbench
========================================

// Module: mptw_flush_controller
// PURPOSE
//  Initiator side of the MPT-walker pipeline flush ctrl/status protocol.
//  - Accepts one flush request (NONE/SPEC/ALL) from the walker front-end.
//  - Drives the per-stage flush ctrl ports of NUM_STAGES pipeline stages.
//  - Collects each stage's flushed/busy status.
//  - Holds off upstream producers while a flush is in flight.
//  - Returns a single completion response.
// PARAMETERS
//  NUM_STAGES      4    number of pipeline stages controlled (>=1)
//  TIMEOUT_CYCLES  64   max cycles in ISSUE/DRAIN before forced completion (MPTW_FLUSH_TIMEOUT_EN only)
// PORTS
//  clk_i              in   1                          clock
//  rst_ni             in   1                          reset, asynchronous, active-low
//  req_valid_i        in   1                          flush request valid
//  req_ready_o        out  1                          request accepted when valid&ready
//  req_type_i         in   $bits(mptw_flush_ctrl_e)   requested flush type
//  m_ctrl_flush_o     out  NUM_STAGES x flush_ctrl    per-stage flush command
//  s_status_flushed_i in   NUM_STAGES x flush_status  per-stage flushed status
//  s_status_busy_i    in   NUM_STAGES                 per-stage busy (holds data)
//  s_status_stalled_i in   NUM_STAGES                 per-stage stalled (observed, OR-reduced)
//  hold_o             out  1                          blocks new transactions entering pipeline
//  any_stalled_o      out  1                          OR of s_status_stalled_i, registered
//  rsp_valid_o        out  1                          flush completion valid
//  rsp_ready_i        in   1                          completion consumed
//  rsp_timeout_o      out  1                          completion forced by timeout; valid with rsp_valid_o
// BEHAVIOUR
//  - Reset (rst_ni low, async): state IDLE; ack mask 0; timer 0.
//    All outputs 0; m_ctrl_flush_o all MPT_FLUSH_NONE.
//    req_ready_o is 0 during reset and first rises the cycle after rst_ni deasserts (reset-done flop).
//  - Reset mid-flush: abandon the flush immediately; no response is issued.
//  - FSM states: IDLE, ISSUE, DRAIN, RESP.
//    - req_ready_o = 1 only in IDLE; hold_o = 1 in ISSUE, DRAIN and RESP.
//  - IDLE, on req_valid_i & req_ready_o:
//    - Latch type; clear ack mask; clear timer.
//    - Type NONE -> RESP. Otherwise -> ISSUE.
//  - ISSUE:
//    - Drive stage i = latched type while ack[i]==0; drive MPT_FLUSH_NONE once ack[i]==1.
//    - Each cycle: ack[i] |= (s_status_flushed_i[i]==MPT_FLUSHED_COMPLETED).
//    - When the mask including the current cycle's acks is all-ones:
//      - type ALL -> DRAIN;
//      - type SPEC -> RESP.
//    - Minimum latency, request accept to rsp_valid_o: SPEC 2 cycles (1 in ISSUE), ALL 3 cycles.
//  - DRAIN (ALL only): wait until all busy==0, then -> RESP. Upstream is held by hold_o.
//  - RESP: rsp_valid_o=1 until rsp_ready_i; on handshake -> IDLE.
//    - rsp_valid_o/rsp_timeout_o are stable while waiting.
//  - A request presented outside IDLE is not accepted and waits (no coalescing).
//  - Ack mask width = NUM_STAGES. Stages that ack early are never re-flushed.
//  - rsp_ready_i is high-tolerant: only the handshake in RESP has effect.
// CONFIGURATION
//  MPTW_FLUSH_TIMEOUT_EN defined:
//    - Counter of $clog2(TIMEOUT_CYCLES+1) bits runs in ISSUE and DRAIN; saturates, never wraps.
//    - When it reaches TIMEOUT_CYCLES -> RESP with rsp_timeout_o=1.
//  MPTW_FLUSH_TIMEOUT_EN undefined:
//    - No counter; ISSUE/DRAIN wait indefinitely; rsp_timeout_o tied 0.
// STRUCTURE
//  mptw_pkg (shared package) holds:
//    - mptw_flush_ctrl_e {MPT_FLUSH_NONE, MPT_FLUSH_SPEC, MPT_FLUSH_ALL};
//    - mptw_flush_status_e {MPT_FLUSHED_NONE, MPT_FLUSHED_COMPLETED};
//    - the FSM state typedef.
//  Ports use the pipelining.svh port macros.
//  No sub-module; ack mask and timer are inline.
// TESTING
//  - ALL, 4 stages all ack in cycle 1, busy=0 -> ctrl=ALL for 1 cycle; rsp_valid_o at cycle 3; timeout=0.
//  - SPEC, stage 2 acks 3 cycles late -> only stage 2 still sees SPEC in cycles 2-3; rsp after its ack.
//  - ALL, busy[1] held 1 for 5 cycles after acks -> stays in DRAIN; rsp 1 cycle after busy drops.
//  - NONE request -> no ctrl asserted; rsp_valid_o next cycle; rsp_ready_i low 4 cycles -> rsp held stable.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=8, stage 0 never acks -> rsp_valid_o & rsp_timeout_o after 8 ISSUE cycles.
//  - rst_ni pulsed low in DRAIN -> outputs 0 asynchronously; no rsp; req_ready_o=1 on 2nd cycle after release.

Source files
------------

// File: rtl/mptw_pkg.sv
// Shared MPT-walker types: per-stage flush command/status encodings and the
// flush controller FSM state.
package mptw_pkg;

  typedef enum logic [1:0] {
    MPT_FLUSH_NONE = 2'd0,
    MPT_FLUSH_SPEC = 2'd1,
    MPT_FLUSH_ALL  = 2'd2
  } mptw_flush_ctrl_e;

  typedef enum logic {
    MPT_FLUSHED_NONE      = 1'b0,
    MPT_FLUSHED_COMPLETED = 1'b1
  } mptw_flush_status_e;

  typedef enum logic [1:0] {
    FLUSH_ST_IDLE  = 2'd0,
    FLUSH_ST_ISSUE = 2'd1,
    FLUSH_ST_DRAIN = 2'd2,
    FLUSH_ST_RESP  = 2'd3
  } mptw_flush_state_e;

endpackage

// File: rtl/mptw_flush_controller.sv
// Flush initiator for the MPT-walker pipeline: issues per-stage flush commands,
// collects acks/busy, holds upstream and returns one completion. Optional
// watchdog enabled by defining MPTW_FLUSH_TIMEOUT_EN.
module mptw_flush_controller
  import mptw_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // Handshakes: a transfer happens on a cycle where valid & ready are both 1;
  // valid never depends on ready, and the initiator holds valid/payload stable
  // until the transfer.
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  mptw_flush_ctrl_e        req_type_i,
  output mptw_flush_ctrl_e        m_ctrl_flush_o     [NUM_STAGES],
  input  mptw_flush_status_e      s_status_flushed_i [NUM_STAGES],
  input  logic [NUM_STAGES-1:0]   s_status_busy_i,
  input  logic [NUM_STAGES-1:0]   s_status_stalled_i,
  output logic                    hold_o,
  output logic                    any_stalled_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_timeout_o,
  output mptw_flush_state_e       state_o
);

  mptw_flush_state_e     state_q, state_d;
  mptw_flush_ctrl_e      type_q, type_d;
  logic [NUM_STAGES-1:0] ack_q, ack_d, ack_now;
  logic                  timeout_q, timeout_d;
  logic                  rst_done_q;
  logic                  any_stalled_q;
  logic                  accept;
  logic                  timeout_hit;

  assign accept = req_valid_i & req_ready_o;

`ifdef MPTW_FLUSH_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q;
  logic               timer_run;

  assign timer_run = (state_q == FLUSH_ST_ISSUE) || (state_q == FLUSH_ST_DRAIN);

  // Saturating: the watchdog must never wrap back into a "fresh" window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (accept) begin
      timer_q <= '0;
    end else if (timer_run && (timer_q != TIMER_MAX)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Fires on the cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = timer_run && (timer_q >= TIMER_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    ack_now = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      ack_now[i] = (s_status_flushed_i[i] == MPT_FLUSHED_COMPLETED);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FLUSH_ST_IDLE;
      type_q        <= MPT_FLUSH_NONE;
      ack_q         <= '0;
      timeout_q     <= 1'b0;
      rst_done_q    <= 1'b0;
      any_stalled_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      ack_q         <= ack_d;
      timeout_q     <= timeout_d;
      rst_done_q    <= 1'b1;
      any_stalled_q <= |s_status_stalled_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    ack_d     = ack_q;
    timeout_d = timeout_q;
    unique case (state_q)
      FLUSH_ST_IDLE: begin
        if (accept) begin
          type_d    = req_type_i;
          ack_d     = '0;
          timeout_d = 1'b0;
          state_d   = (req_type_i == MPT_FLUSH_NONE) ? FLUSH_ST_RESP : FLUSH_ST_ISSUE;
        end
      end
      FLUSH_ST_ISSUE: begin
        ack_d = ack_q | ack_now;
        // Normal completion wins over a watchdog expiring in the same cycle.
        if (&(ack_q | ack_now)) begin
          state_d = (type_q == MPT_FLUSH_ALL) ? FLUSH_ST_DRAIN : FLUSH_ST_RESP;
        end else if (timeout_hit) begin
          state_d   = FLUSH_ST_RESP;
          timeout_d = 1'b1;
        end
      end
      FLUSH_ST_DRAIN: begin
        if (~|s_status_busy_i) begin
          state_d = FLUSH_ST_RESP;
        end else if (timeout_hit) begin
          state_d   = FLUSH_ST_RESP;
          timeout_d = 1'b1;
        end
      end
      FLUSH_ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = FLUSH_ST_IDLE;
        end
      end
      default: state_d = FLUSH_ST_IDLE;
    endcase
  end

  // Stages already acked drop back to NONE so they are never re-flushed.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      m_ctrl_flush_o[i] = MPT_FLUSH_NONE;
      if ((state_q == FLUSH_ST_ISSUE) && !ack_q[i]) begin
        m_ctrl_flush_o[i] = type_q;
      end
    end
  end

  assign req_ready_o   = rst_done_q && (state_q == FLUSH_ST_IDLE);
  assign hold_o        = (state_q != FLUSH_ST_IDLE);
  assign rsp_valid_o   = (state_q == FLUSH_ST_RESP);
  assign rsp_timeout_o = (state_q == FLUSH_ST_RESP) && timeout_q;
  assign any_stalled_o = any_stalled_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mptw_flush_controller.sv
// Directed bench for mptw_flush_controller: a timeline model derives every
// output per cycle offset from the accepted request and checks it at negedge.
module tb_mptw_flush_controller;
  import mptw_pkg::*;

  localparam int NS = 4;
  localparam int TO = 8;
`ifdef MPTW_FLUSH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  mptw_flush_ctrl_e   req_type;
  mptw_flush_ctrl_e   ctrl [NS];
  mptw_flush_status_e flushed [NS];
  logic [NS-1:0]      busy;
  logic [NS-1:0]      stalled;
  logic               hold;
  logic               any_st;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_to;
  mptw_flush_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mptw_flush_controller #(.NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_type_i(req_type),
    .m_ctrl_flush_o(ctrl), .s_status_flushed_i(flushed),
    .s_status_busy_i(busy), .s_status_stalled_i(stalled),
    .hold_o(hold), .any_stalled_o(any_st),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_timeout_o(rsp_to),
    .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scenario description and timeline model ----------------
  int               mode;       // 0: in/just out of reset, 1: idle, 2: flush
  int               off;        // cycle offset from the accept cycle
  mptw_flush_ctrl_e sc_type;
  int               sc_ack [NS];
  logic [NS-1:0]    sc_busy_mask;
  int               sc_busy_t, sc_rdy_delay;
  bit               sc_rdy_always, sc_hold_valid;
  int               m_rsp_start, m_rsp_end, m_last_issue;
  bit               m_to;
  int               first_rsp;
  bit               exp_any;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s mode=%0d off=%0d: got %0d, expected %0d", name, mode, off, act, exp);
    end
  endtask

  task automatic set_sc(input mptw_flush_ctrl_e t, input int a0, input int a1, input int a2,
                        input int a3, input logic [NS-1:0] bmask, input int bt,
                        input int rdly, input bit ralways, input bit vhold);
    int issue_end, e;
    sc_type = t;
    sc_ack[0] = a0; sc_ack[1] = a1; sc_ack[2] = a2; sc_ack[3] = a3;
    sc_busy_mask = bmask; sc_busy_t = bt;
    sc_rdy_delay = rdly; sc_rdy_always = ralways; sc_hold_valid = vhold;
    issue_end = 0;
    for (int i = 0; i < NS; i++) if (sc_ack[i] > issue_end) issue_end = sc_ack[i];
    m_to = 1'b0;
    if (t == MPT_FLUSH_NONE) begin
      e = 0;
      issue_end = 0;
    end else if (t == MPT_FLUSH_SPEC) begin
      e = issue_end;
    end else begin
      e = issue_end + 1;
      if (bmask != '0 && bt > e) e = bt;
    end
    if (TO_EN && t != MPT_FLUSH_NONE && e > TO) begin
      e = TO;
      m_to = 1'b1;
    end
    m_rsp_start  = e + 1;
    m_last_issue = (issue_end < e) ? issue_end : e;
    m_rsp_end    = m_rsp_start + rdly;
  endtask

  // --------------------------------- driver --------------------------------
  task automatic quiet_inputs();
    req_valid = 1'b0;
    req_type  = MPT_FLUSH_NONE;
    for (int i = 0; i < NS; i++) flushed[i] = MPT_FLUSHED_NONE;
    busy      = '0;
    stalled   = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    mode = 1;
    for (int c = 0; c < n; c++) begin
      quiet_inputs();
      stalled = (c % 2 == 1) ? 4'b1000 : 4'b0000;
      @(posedge clk); #1;
    end
  endtask

  // Runs the current scenario; abort_at >= 0 pulls rst_ni low inside that cycle.
  task automatic run_flush(input int abort_at);
    first_rsp = -1;
    mode = 2;
    for (int t = 0; t <= m_rsp_end; t++) begin
      off       = t;
      req_valid = (t == 0) || sc_hold_valid;
      req_type  = sc_type;
      for (int i = 0; i < NS; i++)
        flushed[i] = (t == sc_ack[i]) ? MPT_FLUSHED_COMPLETED : MPT_FLUSHED_NONE;
      busy      = (t < sc_busy_t) ? sc_busy_mask : '0;
      stalled   = (t % 3 == 1) ? 4'b0100 : 4'b0000;
      rsp_ready = sc_rdy_always || (t >= m_rsp_start + sc_rdy_delay);
      if (t == abort_at) begin
        #2;
        rst_n = 1'b0;
        mode  = 0;
        return;
      end
      @(posedge clk); #1;
    end
    quiet_inputs();
    mode = 1;
  endtask

  // ------------------------------ compare process --------------------------
  always @(negedge clk) begin
    bit e_rdy, e_hold, e_rv, e_to;
    int e_ctrl;
    e_rdy = 1'b0; e_hold = 1'b0; e_rv = 1'b0; e_to = 1'b0;
    if (mode == 1) begin
      e_rdy = 1'b1;
    end else if (mode == 2) begin
      e_rdy  = (off == 0);
      e_hold = (off >= 1);
      e_rv   = (off >= m_rsp_start);
      e_to   = e_rv && m_to;
      if (rsp_valid && first_rsp < 0) first_rsp = off;
    end
    chk("req_ready", int'(req_ready), int'(e_rdy));
    chk("hold", int'(hold), int'(e_hold));
    chk("rsp_valid", int'(rsp_valid), int'(e_rv));
    chk("rsp_timeout", int'(rsp_to), int'(e_to));
    chk("any_stalled", int'(any_st), int'(exp_any));
    for (int i = 0; i < NS; i++) begin
      e_ctrl = int'(MPT_FLUSH_NONE);
      if (mode == 2 && sc_type != MPT_FLUSH_NONE && off >= 1 && off <= sc_ack[i] &&
          off <= m_last_issue)
        e_ctrl = int'(sc_type);
      chk($sformatf("ctrl[%0d]", i), int'(ctrl[i]), e_ctrl);
    end
    exp_any = rst_n ? |stalled : 1'b0;
  end

  // --------------------------------- sequence ------------------------------
  initial begin
    rst_n = 1'b0;
    mode  = 0;
    off   = 0;
    exp_any = 1'b0;
    first_rsp = -1;
    quiet_inputs();
    set_sc(MPT_FLUSH_NONE, 0, 0, 0, 0, '0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(2);

    // ALL, every stage acks in cycle 1, nothing busy.
    set_sc(MPT_FLUSH_ALL, 1, 1, 1, 1, '0, 0, 0, 1'b0, 1'b0);
    run_flush(-1);
    chk("lat_all_fast", first_rsp, 3);
    idle_cycles(1);

    // SPEC, stage 2 late; request kept valid through the flush, then reused.
    set_sc(MPT_FLUSH_SPEC, 1, 1, 3, 1, '0, 0, 2, 1'b0, 1'b1);
    run_flush(-1);
    chk("lat_spec_late", first_rsp, 4);

    // ALL, busy[1] stays high 5 cycles after the last ack.
    set_sc(MPT_FLUSH_ALL, 1, 2, 1, 2, 4'b0010, 8, 1, 1'b0, 1'b0);
    run_flush(-1);
    chk("lat_all_drain", first_rsp, 9);
    idle_cycles(1);

    // NONE, completion consumer stalls 4 cycles.
    set_sc(MPT_FLUSH_NONE, 0, 0, 0, 0, '0, 0, 4, 1'b0, 1'b0);
    run_flush(-1);
    chk("lat_none", first_rsp, 1);
    idle_cycles(1);

    // SPEC with rsp_ready held high throughout.
    set_sc(MPT_FLUSH_SPEC, 2, 1, 3, 2, '0, 0, 0, 1'b1, 1'b0);
    run_flush(-1);
    chk("lat_spec_rdy_high", first_rsp, 4);
    idle_cycles(2);

`ifdef MPTW_FLUSH_TIMEOUT_EN
    // Stage 0 never acks: watchdog forces completion.
    set_sc(MPT_FLUSH_ALL, 100, 1, 1, 1, '0, 0, 1, 1'b0, 1'b0);
    run_flush(-1);
    chk("lat_timeout", first_rsp, TO + 1);
    idle_cycles(2);
`endif

    // Reset pulse while draining: immediate quiet outputs, no completion.
    set_sc(MPT_FLUSH_ALL, 1, 1, 1, 1, 4'b1111, 50, 0, 1'b0, 1'b0);
    run_flush(4);
    #1;
    chk("async_rst_hold", int'(hold), 0);
    chk("async_rst_ready", int'(req_ready), 0);
    chk("async_rst_rsp", int'(rsp_valid), 0);
    chk("async_rst_ctrl0", int'(ctrl[0]), int'(MPT_FLUSH_NONE));
    quiet_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(4);

    // Back-to-back after reset recovery.
    set_sc(MPT_FLUSH_SPEC, 1, 2, 1, 1, '0, 0, 1, 1'b0, 1'b0);
    run_flush(-1);
    chk("lat_spec_after_rst", first_rsp, 3);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
